seven_seg_scan: RTL and testbench

Time-multiplexed driver for the board's 4-digit common-anode seven-segment display; the consuming end of the clock core's BCD digit outputs. It snapshots the four BCD digits once per scan frame and scans them round-robin onto shared cathodes. During setup mode it blinks the digit being edited. In run mode it flashes a colon (decimal point on the hour-lower digit) at the half-second rate.

---
 rtl/seven_seg_pkg.sv | 27 ++
 rtl/seven_seg_decode.sv | 26 ++
 rtl/seven_seg_scan.sv | 134 +++++++++++++
 tb/tb_seven_seg_scan.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seven_seg_pkg.sv
// Shared constants, types and helpers for the four-digit seven-segment scanner.
// Segment patterns are active-low, ordered {g,f,e,d,c,b,a}.
package seven_seg_pkg;

    typedef logic [1:0] slot_t;

    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_DASH  = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    localparam logic [3:0] AN_ALL_OFF = 4'b1111;

    // Slot k is physically an[k]; the leftmost slot holds the hours-tens digit (loc 0).
    function automatic logic [1:0] slot_to_loc(input slot_t slot);
        return 2'd3 - slot;
    endfunction

endpackage

// File: rtl/seven_seg_decode.sv
// Combinational BCD to active-low segment pattern; non-BCD codes show a dash.
module seven_seg_decode
    import seven_seg_pkg::*;
(
    input  logic [3:0] bcd,
    output logic [6:0] pattern
);

    always_comb begin
        pattern = SEG_DASH;
        case (bcd)
            4'd0:    pattern = SEG_0;
            4'd1:    pattern = SEG_1;
            4'd2:    pattern = SEG_2;
            4'd3:    pattern = SEG_3;
            4'd4:    pattern = SEG_4;
            4'd5:    pattern = SEG_5;
            4'd6:    pattern = SEG_6;
            4'd7:    pattern = SEG_7;
            4'd8:    pattern = SEG_8;
            4'd9:    pattern = SEG_9;
            default: pattern = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/seven_seg_scan.sv
// Time-multiplexed 4-digit common-anode display driver with frame snapshot,
// edit-digit blink and run-mode colon. Optional: LEADING_ZERO_BLANK_EN.
module seven_seg_scan
    import seven_seg_pkg::*;
#(
    parameter int unsigned REFRESH_DIV = 49999,
    parameter int unsigned BLINK_DIV   = 24999999
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] hourUpper,
    input  logic [3:0] hourLower,
    input  logic [3:0] minuteUpper,
    input  logic [3:0] minuteLower,
    input  logic       setupMode,
    input  logic [1:0] loc,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp
);

    localparam int unsigned RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int unsigned BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_DIV - 1);
    localparam logic [BW-1:0] BLINK_LAST   = BW'(BLINK_DIV - 1);

    logic [RW-1:0]     refresh_q, refresh_d;
    slot_t             slot_q, slot_d;
    logic [BW-1:0]     blink_q, blink_d;
    logic              phase_q, phase_d;
    logic [3:0][3:0]   shadow_q, shadow_d;
    logic              setup_q;
    logic [1:0]        loc_q;
    logic [3:0]        an_d;
    logic [6:0]        seg_d;
    logic              dp_d;

    logic              refresh_wrap;
    logic              frame_wrap;
    logic              blink_wrap;
    logic              restart;
    logic [1:0]        cur_loc;
    logic [3:0]        cur_digit;
    logic [6:0]        cur_pattern;
    logic              edit_blank;
    logic              lead_blank;

    assign refresh_wrap = (refresh_q == REFRESH_LAST);
    assign frame_wrap   = refresh_wrap && (slot_q == 2'd3);
    assign blink_wrap   = (blink_q == BLINK_LAST);
    assign restart      = (setupMode && !setup_q) || (loc != loc_q);

    always_comb begin
        refresh_d = refresh_wrap ? '0 : refresh_q + RW'(1);
        slot_d    = refresh_wrap ? slot_q + 2'd1 : slot_q;
    end

    // Shadow indexed by loc so the edit selector compares directly against it.
    always_comb begin
        shadow_d = shadow_q;
        if (frame_wrap) begin
            shadow_d[0] = hourUpper;
            shadow_d[1] = hourLower;
            shadow_d[2] = minuteUpper;
            shadow_d[3] = minuteLower;
        end
    end

    // A restart outranks a coincident wrap so the new edit digit appears at once.
    always_comb begin
        blink_d = blink_q + BW'(1);
        phase_d = phase_q;
        if (restart) begin
            blink_d = '0;
            phase_d = 1'b1;
        end else if (blink_wrap) begin
            blink_d = '0;
            phase_d = ~phase_q;
        end
    end

    assign cur_loc   = slot_to_loc(slot_q);
    assign cur_digit = shadow_q[cur_loc];

    seven_seg_decode u_decode (
        .bcd     (cur_digit),
        .pattern (cur_pattern)
    );

    assign edit_blank = setup_q && !phase_q && (loc_q == cur_loc);

`ifdef LEADING_ZERO_BLANK_EN
    assign lead_blank = !setup_q && (slot_q == 2'd3) && (shadow_q[0] == 4'd0);
`else
    assign lead_blank = 1'b0;
`endif

    always_comb begin
        an_d  = (refresh_q == '0) ? AN_ALL_OFF : ~(4'b0001 << slot_q);
        seg_d = edit_blank ? SEG_BLANK : cur_pattern;
        dp_d  = !(!setup_q && phase_q && (slot_q == 2'd2));
        if (lead_blank) begin
            an_d  = AN_ALL_OFF;
            seg_d = SEG_BLANK;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            refresh_q <= '0;
            slot_q    <= 2'd0;
            blink_q   <= '0;
            phase_q   <= 1'b1;
            shadow_q  <= '0;
            setup_q   <= 1'b0;
            loc_q     <= 2'd0;
            an        <= AN_ALL_OFF;
            seg       <= SEG_BLANK;
            dp        <= 1'b1;
        end else begin
            refresh_q <= refresh_d;
            slot_q    <= slot_d;
            blink_q   <= blink_d;
            phase_q   <= phase_d;
            shadow_q  <= shadow_d;
            setup_q   <= setupMode;
            loc_q     <= loc;
            an        <= an_d;
            seg       <= seg_d;
            dp        <= dp_d;
        end
    end

endmodule

// File: tb/tb_seven_seg_scan.sv
// Randomized self-checking bench for seven_seg_scan against a cycle-count reference model.
module tb_seven_seg_scan;

    localparam int REF = 4;
    localparam int BLK = 10;
    localparam int FRAME = 4 * REF;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] hourUpper = '0, hourLower = '0, minuteUpper = '0, minuteLower = '0;
    logic       setupMode = 1'b0;
    logic [1:0] loc = 2'd0;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;

    int total = 0;
    int bad = 0;

    // Model state: edges since reset, edge of last blink restart, last-frame digits,
    // and the mode/loc seen at the previous edge.
    int         n = 0;
    int         r = 0;
    logic [3:0] m_sh [4];
    logic       m_setup = 1'b0;
    logic [1:0] m_loc = 2'd0;
    logic [3:0] exp_an;
    logic [6:0] exp_seg;
    logic       exp_dp;

    seven_seg_scan #(
        .REFRESH_DIV (REF),
        .BLINK_DIV   (BLK)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hourUpper   (hourUpper),
        .hourLower   (hourLower),
        .minuteUpper (minuteUpper),
        .minuteLower (minuteLower),
        .setupMode   (setupMode),
        .loc         (loc),
        .an          (an),
        .seg         (seg),
        .dp          (dp)
    );

    always #5 clk = ~clk;

    // Active-high lit segments {g..a} for a BCD digit; non-BCD lights g only.
    function automatic logic [6:0] lit(input logic [3:0] d);
        case (d)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    function automatic bit model_phase();
        return (((n - r) / BLK) % 2) == 0;
    endfunction

    function automatic int model_slot();
        return (n / REF) % 4;
    endfunction

    // Advance one clock: form the expectation from the pre-edge model, then update it.
    task automatic tick();
        int  refr, sl, li;
        bit  ph;
        if (rst) begin
            exp_an = 4'hF; exp_seg = 7'h7F; exp_dp = 1'b1;
        end else begin
            refr = n % REF;
            sl   = model_slot();
            li   = 3 - sl;
            ph   = model_phase();
            exp_an  = (refr == 0) ? 4'hF : ~(4'b0001 << sl);
            exp_seg = ~lit(m_sh[li]);
            if (m_setup && !ph && (int'(m_loc) == li)) exp_seg = 7'h7F;
            exp_dp  = !(!m_setup && ph && sl == 2);
`ifdef LEADING_ZERO_BLANK_EN
            if (!m_setup && sl == 3 && m_sh[0] == 4'd0) begin
                exp_an = 4'hF; exp_seg = 7'h7F;
            end
`endif
        end
        @(posedge clk);
        if (rst) begin
            n = 0; r = 0; m_setup = 1'b0; m_loc = 2'd0;
            for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
        end else begin
            n++;
            if (n % FRAME == 0) begin
                m_sh[0] = hourUpper; m_sh[1] = hourLower;
                m_sh[2] = minuteUpper; m_sh[3] = minuteLower;
            end
            if ((setupMode && !m_setup) || (loc != m_loc)) r = n;
            m_setup = setupMode;
            m_loc   = loc;
        end
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
                bad++;
                $display("FAIL reset an=%b/1111 seg=%b/1111111 dp=%b/1", an, seg, dp);
            end
        end
        rst = 1'b0;
        hourUpper = 4'd1; hourLower = 4'd2; minuteUpper = 4'd3; minuteLower = 4'd4;
        for (int i = 0; i < 2; i++) begin
            tick();
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL first_slot c=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                         i, an, exp_an, seg, exp_seg, dp, exp_dp);
            end
        end
        total++;
        if ({an, seg} !== {4'b1110, 7'b1000000}) begin
            bad++;
            $display("FAIL first_anode an=%b/1110 seg=%b/1000000", an, seg);
        end
    endtask

    task automatic test_scan();
        for (int f = 0; f < 6; f++) begin
            if (f >= 2) begin
                hourUpper   = 4'($urandom_range(0, 15));
                hourLower   = 4'($urandom_range(0, 15));
                minuteUpper = 4'($urandom_range(0, 15));
                minuteLower = 4'($urandom_range(0, 15));
            end
            for (int c = 0; c < 2 * FRAME; c++) begin
                tick();
                total++;
                if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                    bad++;
                    $display("FAIL scan n=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                             n, an, exp_an, seg, exp_seg, dp, exp_dp);
                end
            end
        end
    endtask

    task automatic test_snapshot();
        hourUpper = 4'd1; hourLower = 4'd2; minuteUpper = 4'd3; minuteLower = 4'd4;
        for (int c = 0; c < 2 * FRAME; c++) tick();
        for (int c = 0; c < FRAME && model_slot() != 2; c++) tick();
        minuteLower = 4'd7;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL snapshot n=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                         n, an, exp_an, seg, exp_seg, dp, exp_dp);
            end
        end
        // Inputs churn every cycle; each frame must show only wrap-time values.
        for (int c = 0; c < 3 * FRAME; c++) begin
            minuteLower = 4'($urandom_range(0, 9));
            hourLower   = 4'($urandom_range(0, 9));
            tick();
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL tear n=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                         n, an, exp_an, seg, exp_seg, dp, exp_dp);
            end
        end
    endtask

    task automatic test_setup_blink();
        int blanks = 0;
        hourUpper = 4'd1; hourLower = 4'd2; minuteUpper = 4'd3; minuteLower = 4'd4;
        for (int c = 0; c < 2 * FRAME; c++) tick();
        setupMode = 1'b1;
        loc = 2'd1;
        for (int c = 0; c < 80; c++) begin
            tick();
            if (an == 4'b1011 && seg == 7'h7F) blanks++;
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL setup_blink n=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                         n, an, exp_an, seg, exp_seg, dp, exp_dp);
            end
        end
        total++;
        if (blanks == 0) begin
            bad++;
            $display("FAIL blink_seen blanks=%0d required>0", blanks);
        end
    endtask

    task automatic test_loc_restart();
        for (int c = 0; c < 4 * BLK && model_phase(); c++) tick();
        total++;
        if (model_phase()) begin
            bad++;
            $display("FAIL phase0_wait timeout phase=1 required=0");
        end
        loc = 2'd2;
        for (int c = 0; c < 3 * BLK; c++) begin
            tick();
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL loc_restart n=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                         n, an, exp_an, seg, exp_seg, dp, exp_dp);
            end
        end
        for (int c = 0; c < 300; c++) begin
            if ($urandom_range(0, 15) == 0) loc = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 40) == 0) setupMode = ~setupMode;
            tick();
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL rand_mode n=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                         n, an, exp_an, seg, exp_seg, dp, exp_dp);
            end
        end
        setupMode = 1'b0;
    endtask

    task automatic test_dash();
        hourUpper = 4'hC;
        for (int c = 0; c < 3 * FRAME; c++) begin
            tick();
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL dash n=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                         n, an, exp_an, seg, exp_seg, dp, exp_dp);
            end
            if (c >= 2 * FRAME && exp_an == 4'b0111) begin
                total++;
                if (seg !== 7'b0111111) begin
                    bad++;
                    $display("FAIL dash_pattern seg=%b required=0111111", seg);
                end
            end
        end
    endtask

    task automatic test_mid_reset();
        for (int c = 0; c < FRAME + 6; c++) tick();
        rst = 1'b1;
        tick();
        total++;
        if ({an, seg, dp} !== {4'hF, 7'h7F, 1'b1}) begin
            bad++;
            $display("FAIL mid_reset an=%b/1111 seg=%b/1111111 dp=%b/1", an, seg, dp);
        end
        rst = 1'b0;
        for (int c = 0; c < 2 * FRAME; c++) begin
            tick();
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL after_reset n=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                         n, an, exp_an, seg, exp_seg, dp, exp_dp);
            end
        end
    endtask

`ifdef LEADING_ZERO_BLANK_EN
    task automatic test_lead_zero();
        setupMode = 1'b0;
        hourUpper = 4'd0;
        for (int c = 0; c < 6 * FRAME; c++) begin
            if (c == 3 * FRAME) begin
                setupMode = 1'b1;
                loc = 2'd0;
            end
            tick();
            total++;
            if ({an, seg, dp} !== {exp_an, exp_seg, exp_dp}) begin
                bad++;
                $display("FAIL lead_zero n=%0d an=%b/%b seg=%b/%b dp=%b/%b",
                         n, an, exp_an, seg, exp_seg, dp, exp_dp);
            end
        end
        setupMode = 1'b0;
    endtask
`endif

    initial begin
        for (int i = 0; i < 4; i++) m_sh[i] = 4'd0;
        test_reset();
        test_scan();
        test_snapshot();
        test_setup_blink();
        test_loc_restart();
        test_dash();
        test_mid_reset();
`ifdef LEADING_ZERO_BLANK_EN
        test_lead_zero();
`endif
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
